// File: rtl/ov_bus_pkg.sv
// Shared constants for the register-bus arbiter: default widths,
// FSM state encodings and master indices.
package ov_bus_pkg;

    localparam int ADDR_W_DEF = 31;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/bus_arb_rr.sv
// Combinational two-way round-robin picker with optional lock mask.
// A non-zero lock_own restricts eligibility to the owning master.
module bus_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] lock_own,
    output logic       gnt_idx,
    output logic       gnt_valid
);
    import ov_bus_pkg::*;

    logic [1:0] elig;

    always_comb begin
        elig      = (|lock_own) ? (req & lock_own) : req;
        gnt_valid = |elig;
        gnt_idx   = M0;
        if (&elig) begin
            gnt_idx = ~last;
        end else if (elig[M1]) begin
            gnt_idx = M1;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-master register-bus arbiter, one transaction in flight, registered outputs.
// Define ARB_LOCK_EN to let a master hold the bus across transactions via mN_lock.
module reg_bus_arbiter
    import ov_bus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [DATA_W-1:0] data_bus_wr,
    output logic              wr_strobe,
    output logic              rd_strobe,
    input  logic [DATA_W-1:0] data_bus_rd
);

    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    logic [1:0] state;
    logic       win;
    logic       last;
    logic       we_q;
    logic [2:0] cnt;
    logic       gnt_idx;
    logic       gnt_valid;
    logic [1:0] lock_own;
    logic       sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign sel_we    = gnt_idx ? m1_we    : m0_we;
    assign sel_addr  = gnt_idx ? m1_addr  : m0_addr;
    assign sel_wdata = gnt_idx ? m1_wdata : m0_wdata;

`ifdef ARB_LOCK_EN
    logic       owned;
    logic       owner;
    logic [1:0] lock;

    assign lock     = {m1_lock, m0_lock};
    // Ownership only gates arbitration while the owner still holds lock.
    assign lock_own = (owned && lock[owner]) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owned <= 1'b0;
            owner <= M0;
        end else if (state == ACK && lock[win]) begin
            owned <= 1'b1;
            owner <= win;
        end else if (state == IDLE && owned && !lock[owner]) begin
            owned <= 1'b0;
        end
    end
`else
    logic unused_lock;

    assign lock_own    = 2'b00;
    assign unused_lock = m0_lock ^ m1_lock;
`endif

    bus_arb_rr u_rr (
        .req       ({m1_req, m0_req}),
        .last      (last),
        .lock_own  (lock_own),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            win         <= M0;
            last        <= M1;
            we_q        <= 1'b0;
            cnt         <= '0;
            addr_bus    <= '0;
            data_bus_wr <= '0;
            wr_strobe   <= 1'b0;
            rd_strobe   <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            addr_bus    <= '0;
            data_bus_wr <= '0;
            wr_strobe   <= 1'b0;
            rd_strobe   <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        state       <= ISSUE;
                        win         <= gnt_idx;
                        we_q        <= sel_we;
                        addr_bus    <= sel_addr;
                        data_bus_wr <= sel_we ? sel_wdata : '0;
                        wr_strobe   <= sel_we;
                        rd_strobe   <= ~sel_we;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (we_q) begin
                        state  <= ACK;
                        m0_ack <= (win == M0);
                        m1_ack <= (win == M1);
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    // Slave data is valid in the last wait cycle only.
                    if (cnt == LAT_LAST) begin
                        state  <= ACK;
                        m0_ack <= (win == M0);
                        m1_ack <= (win == M1);
                        if (win == M1) begin
                            m1_rdata <= data_bus_rd;
                        end else begin
                            m0_rdata <= data_bus_rd;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                    last  <= win;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed scenarios plus a
// randomized two-master run against a transaction-level arbitration model.
module tb_reg_bus_arbiter;

    localparam int AW = 31;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] addr_bus;
    logic [DW-1:0] data_bus_wr;
    logic [DW-1:0] data_bus_rd = '0;
    logic          wr_strobe, rd_strobe;

    logic          b_req;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rd = '0;
    logic          b_m0_ack, b_m1_ack, b_wr_strobe, b_rd_strobe;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_data_bus_wr;
    logic [AW-1:0] b_addr_bus;

    int checks = 0;
    int errors = 0;
    int last_srv = 1;
    int cyc = 0;
    int s_due = -1;
    int b_due = -1;
    logic [DW-1:0] s_val = '0;
    logic [DW-1:0] smem [16];

    reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .addr_bus(addr_bus), .data_bus_wr(data_bus_wr),
        .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
        .data_bus_rd(data_bus_rd)
    );

    reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(b_req), .m0_we(1'b0), .m0_addr(b_addr),
        .m0_wdata('0), .m0_lock(1'b0),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr('0),
        .m1_wdata('0), .m1_lock(1'b0),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .addr_bus(b_addr_bus), .data_bus_wr(b_data_bus_wr),
        .wr_strobe(b_wr_strobe), .rd_strobe(b_rd_strobe),
        .data_bus_rd(b_rd)
    );

    // Slave models: small register file, read data returned RD_LATENCY cycles after strobe.
    always @(negedge clk) begin
        if (wr_strobe) smem[addr_bus[3:0]] = data_bus_wr;
        if (rd_strobe) begin
            s_due = cyc + 1;
            s_val = smem[addr_bus[3:0]];
        end
        if (b_rd_strobe) b_due = cyc + 3;
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        data_bus_rd = (cyc == s_due) ? s_val : '0;
        b_rd = (cyc == b_due) ? 32'hCAFE_0003 : '0;
    end

    task automatic new_txn(input int m);
        if (m == 0) begin
            m0_we    = 1'($urandom_range(0, 1));
            m0_addr  = 31'h0100_0000 | AW'($urandom_range(0, 15));
            m0_wdata = $urandom;
            m0_req   = 1'b1;
        end else begin
            m1_we    = 1'($urandom_range(0, 1));
            m1_addr  = 31'h0100_0000 | AW'($urandom_range(0, 15));
            m1_wdata = $urandom;
            m1_req   = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit got;
        bit a0, a1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wr_strobe, rd_strobe, m0_ack, m1_ack} !== 4'b0 || addr_bus !== '0 ||
            data_bus_wr !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
            errors++;
            $display("FAIL rst_outputs: got wr=%b rd=%b ack=%b%b addr=%h wd=%h, want all 0",
                     wr_strobe, rd_strobe, m0_ack, m1_ack, addr_bus, data_bus_wr);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        m0_we = 1'b1; m0_addr = 31'h0100_000F; m0_wdata = 32'h1234; m0_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = m0_ack;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rst_pre_ack: got no m0_ack, want m0_ack within 8 cycles");
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        m1_we = 1'b1; m1_addr = 31'h0100_000E; m1_wdata = 32'h77; m1_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wr_strobe !== 1'b1 || addr_bus !== m1_addr) begin
            errors++;
            $display("FAIL rst_issue: got wr=%b addr=%h, want wr=1 addr=%h",
                     wr_strobe, addr_bus, m1_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (wr_strobe !== 1'b0 || rd_strobe !== 1'b0 || addr_bus !== '0 || data_bus_wr !== '0) begin
            errors++;
            $display("FAIL rst_async: got wr=%b rd=%b addr=%h, want 0 0 0",
                     wr_strobe, rd_strobe, addr_bus);
        end
        got = 1'b0;
        repeat (3) begin
            @(negedge clk);
            got = got | m1_ack | m0_ack;
        end
        checks++;
        if (got) begin
            errors++;
            $display("FAIL rst_noack: got ack during reset, want none");
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        m0_addr = 31'h0100_0001; m0_wdata = 32'hA; m0_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wr_strobe !== 1'b1 || addr_bus !== m0_addr) begin
            errors++;
            $display("FAIL rst_tie: got wr=%b addr=%h, want wr=1 addr=%h (m0)",
                     wr_strobe, addr_bus, m0_addr);
        end
        for (int i = 0; i < 20 && (m0_req || m1_req); i++) begin
            @(negedge clk);
            a0 = m0_ack; a1 = m1_ack;
            @(posedge clk); #1;
            if (a0) m0_req = 1'b0;
            if (a1) m1_req = 1'b0;
        end
        checks++;
        if (m0_req || m1_req) begin
            errors++;
            $display("FAIL rst_drain: got req pending m0=%b m1=%b, want both served", m0_req, m1_req);
        end
        last_srv = 1;
    endtask

    task automatic test_write();
        m0_we = 1'b1; m0_addr = 31'h0100_0000; m0_wdata = 32'h5; m0_req = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_strobe !== 1'b0) begin
            errors++;
            $display("FAIL wr_early: got wr=%b at T, want 0", wr_strobe);
        end
        @(negedge clk);
        checks++;
        if (wr_strobe !== 1'b1 || rd_strobe !== 1'b0 || addr_bus !== 31'h0100_0000 ||
            data_bus_wr !== 32'h5 || m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL wr_issue: got wr=%b rd=%b addr=%h wd=%h ack=%b, want 1 0 01000000 5 0",
                     wr_strobe, rd_strobe, addr_bus, data_bus_wr, m0_ack);
        end
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b1 || wr_strobe !== 1'b0 || addr_bus !== '0) begin
            errors++;
            $display("FAIL wr_ack: got ack=%b wr=%b addr=%h at T+2, want 1 0 0",
                     m0_ack, wr_strobe, addr_bus);
        end
        @(posedge clk); #1;
        m0_req = 1'b0;
        last_srv = 0;
    endtask

    task automatic test_read();
        m1_we = 1'b0; m1_addr = 31'h0100_0000; m1_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rd_strobe !== 1'b1 || wr_strobe !== 1'b0 || addr_bus !== 31'h0100_0000 ||
            data_bus_wr !== '0) begin
            errors++;
            $display("FAIL rd_issue: got rd=%b wr=%b addr=%h wd=%h, want 1 0 01000000 0",
                     rd_strobe, wr_strobe, addr_bus, data_bus_wr);
        end
        @(negedge clk);
        checks++;
        if (m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL rd_early: got m1_ack=%b at T+2, want 0", m1_ack);
        end
        @(negedge clk);
        checks++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h5) begin
            errors++;
            $display("FAIL rd_data: got ack=%b rdata=%h at T+3, want 1 00000005", m1_ack, m1_rdata);
        end
        @(posedge clk); #1;
        m1_req = 1'b0;
        last_srv = 1;
        b_addr = 31'h0100_0003; b_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (b_rd_strobe !== 1'b1 || b_addr_bus !== 31'h0100_0003) begin
            errors++;
            $display("FAIL rd3_issue: got rd=%b addr=%h, want 1 01000003", b_rd_strobe, b_addr_bus);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (b_m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL rd3_early: got ack=%b at T+4, want 0", b_m0_ack);
        end
        @(negedge clk);
        checks++;
        if (b_m0_ack !== 1'b1 || b_m0_rdata !== 32'hCAFE_0003) begin
            errors++;
            $display("FAIL rd3_data: got ack=%b rdata=%h at T+5, want 1 cafe0003", b_m0_ack, b_m0_rdata);
        end
        @(posedge clk); #1;
        b_req = 1'b0;
    endtask

    task automatic test_alternate();
        int exp_nx;
        int grants;
        bit a0, a1;
        logic [AW-1:0] ea;
        exp_nx = 1 - last_srv;
        grants = 0;
        m0_we = 1'b1; m0_addr = 31'h0100_0004; m0_wdata = 32'hA0;
        m1_we = 1'b1; m1_addr = 31'h0100_0008; m1_wdata = 32'hB1;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int c = 0; c < 80 && (m0_req || m1_req); c++) begin
            @(negedge clk);
            checks++;
            if (wr_strobe && rd_strobe) begin
                errors++;
                $display("FAIL alt_two_strobes: got wr=1 rd=1, want at most one");
            end
            if (wr_strobe) begin
                ea = (exp_nx == 1) ? m1_addr : m0_addr;
                checks++;
                if (addr_bus !== ea) begin
                    errors++;
                    $display("FAIL alt_order: grant %0d got addr=%h, want %h (m%0d)",
                             grants, addr_bus, ea, exp_nx);
                end
                last_srv = exp_nx;
                exp_nx = 1 - exp_nx;
                grants++;
            end
            a0 = m0_ack; a1 = m1_ack;
            @(posedge clk); #1;
            if (grants >= 8) begin
                if (a0) m0_req = 1'b0;
                if (a1) m1_req = 1'b0;
            end
        end
        checks++;
        if (m0_req || m1_req || grants < 8) begin
            errors++;
            $display("FAIL alt_timeout: got grants=%0d req=%b%b, want >=8 and idle",
                     grants, m0_req, m1_req);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] rmem [16];
        logic [DW-1:0] held [2];
        logic [DW-1:0] rd;
        bit hv [2];
        int free_at, s_c, a_c, win, last;
        bit act, wwe, run, strb, ackc, a0, a1;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW+DW+3:0] ev, av;
        foreach (rmem[i]) rmem[i] = smem[i];
        hv[0] = 1'b0; hv[1] = 1'b0;
        held[0] = '0; held[1] = '0;
        free_at = 0; s_c = -1; a_c = -1; win = 0; last = last_srv;
        act = 1'b0; wwe = 1'b0; run = 1'b1; wa = '0; wd = '0;
        m0_lock = 1'b0; m1_lock = 1'b0;
        for (int c = 0; c < 700; c++) begin
            if (c == 500) run = 1'b0;
            if (!run && !act && !m0_req && !m1_req) break;
            @(negedge clk);
            strb = act && c == s_c;
            ackc = act && c == a_c;
            ev = {strb && wwe, strb && !wwe, ackc && win == 0, ackc && win == 1,
                  strb ? wa : {AW{1'b0}}, (strb && wwe) ? wd : {DW{1'b0}}};
            av = {wr_strobe, rd_strobe, m0_ack, m1_ack, addr_bus, data_bus_wr};
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL rand_bus c=%0d: got %h want %h", c, av, ev);
            end
            if (ackc) begin
                rd = (win == 1) ? m1_rdata : m0_rdata;
                if (!wwe) begin
                    checks++;
                    if (rd !== rmem[wa[3:0]]) begin
                        errors++;
                        $display("FAIL rand_rdata c=%0d m%0d: got %h want %h", c, win, rd, rmem[wa[3:0]]);
                    end
                    held[win] = rmem[wa[3:0]];
                    hv[win] = 1'b1;
                end else begin
                    rmem[wa[3:0]] = wd;
                    if (hv[win]) begin
                        checks++;
                        if (rd !== held[win]) begin
                            errors++;
                            $display("FAIL rand_hold c=%0d m%0d: got %h want %h", c, win, rd, held[win]);
                        end
                    end
                end
                act = 1'b0;
                free_at = c + 1;
                last = win;
            end
            if (!act && c >= free_at && (m0_req || m1_req)) begin
                if (m0_req && m1_req) win = 1 - last;
                else win = m1_req ? 1 : 0;
                act = 1'b1;
                wwe = (win == 1) ? m1_we : m0_we;
                wa  = (win == 1) ? m1_addr : m0_addr;
                wd  = (win == 1) ? m1_wdata : m0_wdata;
                s_c = c + 1;
                a_c = c + 2 + (wwe ? 0 : 1);
            end
            a0 = m0_ack; a1 = m1_ack;
            @(posedge clk); #1;
            if (a0) begin
                if (run && $urandom_range(0, 3) != 0) new_txn(0);
                else m0_req = 1'b0;
            end else if (!m0_req && run && $urandom_range(0, 2) == 0) begin
                new_txn(0);
            end
            if (a1) begin
                if (run && $urandom_range(0, 3) != 0) new_txn(1);
                else m1_req = 1'b0;
            end else if (!m1_req && run && $urandom_range(0, 2) == 0) begin
                new_txn(1);
            end
        end
        checks++;
        if (act || m0_req || m1_req) begin
            errors++;
            $display("FAIL rand_drain: got act=%b req=%b%b, want all idle", act, m0_req, m1_req);
        end
        last_srv = last;
    endtask

    task automatic test_lock();
        int g [$];
        int exp_g [4];
        int n1;
        bit a0, a1, d0, d1, s0;
`ifdef ARB_LOCK_EN
        exp_g = '{1, 1, 1, 0};
`else
        exp_g = '{1, 0, 1, 1};
`endif
        n1 = 0; d0 = 1'b0; d1 = 1'b0; s0 = 1'b0;
        m1_we = 1'b0; m1_addr = 31'h0100_0001; m1_lock = 1'b1; m1_req = 1'b1;
        m0_we = 1'b1; m0_addr = 31'h0100_0002; m0_wdata = 32'h22; m0_lock = 1'b0;
        for (int c = 0; c < 80 && !(d0 && d1); c++) begin
            @(negedge clk);
            if (wr_strobe || rd_strobe) g.push_back(addr_bus == m1_addr ? 1 : 0);
            a0 = m0_ack; a1 = m1_ack;
            @(posedge clk); #1;
            if (g.size() >= 1 && !s0) begin
                m0_req = 1'b1;
                s0 = 1'b1;
            end
            if (a0) begin
                m0_req = 1'b0;
                d0 = 1'b1;
            end
            if (a1) begin
                n1++;
                if (n1 == 3) begin
                    m1_req = 1'b0;
                    m1_lock = 1'b0;
                    d1 = 1'b1;
                end
            end
        end
        checks++;
        if (g.size() != 4) begin
            errors++;
            $display("FAIL lock_count: got %0d grants, want 4", g.size());
        end
        for (int i = 0; i < 4 && i < g.size(); i++) begin
            checks++;
            if (g[i] != exp_g[i]) begin
                errors++;
                $display("FAIL lock_order: grant %0d got m%0d, want m%0d", i, g[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_idle();
        repeat (20) begin
            @(negedge clk);
            checks++;
            if ({wr_strobe, rd_strobe, m0_ack, m1_ack} !== 4'b0 || addr_bus !== '0 ||
                data_bus_wr !== '0 || {b_wr_strobe, b_rd_strobe, b_m0_ack, b_m1_ack} !== 4'b0 ||
                b_addr_bus !== '0 || b_data_bus_wr !== '0 || b_m1_rdata !== '0) begin
                errors++;
                $display("FAIL idle_bus: got wr=%b rd=%b ack=%b%b addr=%h wd=%h, want all 0",
                         wr_strobe, rd_strobe, m0_ack, m1_ack, addr_bus, data_bus_wr);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_lock = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
        b_req = 1'b0; b_addr = '0;
        foreach (smem[i]) smem[i] = '0;
        test_reset();
        test_write();
        test_read();
        test_alternate();
        test_random();
        test_lock();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
